cacheline_adapter: RTL and testbench

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

---
 rtl/cacheline_adapter.sv | 106 ++++++++++
 tb/tb_cacheline_adapter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adapter.sv
// Cacheline adapter: turns one 256-bit line read/write request into a burst of
// four 64-bit beats on the memory side, with wait states allowed between beats.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a line request; address/data latched on accept
// S_READ  | burst read, one beat stored per mem_resp
// S_WRITE | burst write, one beat retired per mem_resp
// S_DONE  | one-cycle pmem_resp, then back to S_IDLE
module cacheline_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [255:0] pmem_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [63:0]  mem_wdata,
  input  logic [63:0]  mem_rdata,
  input  logic         mem_resp
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]   state_q;
  logic [1:0]   state_d;
  logic [1:0]   cnt_q;
  logic [26:0]  addr_q;
  logic [255:0] line_q;
  logic [255:0] wbuf_q;
  logic         last_beat;

  assign last_beat = mem_resp && (cnt_q == 2'd3);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pmem_write)
          state_d = S_WRITE;
        else if (pmem_read)
          state_d = S_READ;
      end
      S_READ: begin
        if (last_beat)
          state_d = S_DONE;
      end
      S_WRITE: begin
        if (last_beat)
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Only the line-aligned part of the address is kept, so the burst base is
  // 32-byte aligned by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      line_q  <= '0;
      wbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (pmem_write || pmem_read) begin
            addr_q <= pmem_address[31:5];
            cnt_q  <= 2'd0;
            if (pmem_write)
              wbuf_q <= pmem_wdata;
          end
        end
        S_READ: begin
          if (mem_resp) begin
            line_q[{cnt_q, 6'd0} +: 64] <= mem_rdata;
            cnt_q                       <= cnt_q + 2'd1;
          end
        end
        S_WRITE: begin
          if (mem_resp)
            cnt_q <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_read    = (state_q == S_READ);
  assign mem_write   = (state_q == S_WRITE);
  assign mem_address = {addr_q, 5'd0};
  assign mem_wdata   = wbuf_q[{cnt_q, 6'd0} +: 64];
  assign pmem_resp   = (state_q == S_DONE);
  assign pmem_rdata  = line_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: a memory responder with random wait
// states, a line-level reference memory, and a bus monitor that checks bursts.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pmem_read = 1'b0;
  logic         pmem_write = 1'b0;
  logic [31:0]  pmem_address = '0;
  logic [255:0] pmem_wdata = '0;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata = '0;
  logic         mem_resp = 1'b0;

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit           is_rd;
    logic [31:0]  addr;
    logic [255:0] line;
  } exp_t;

  exp_t exp_q[$];
  logic [255:0] ref_mem  [logic [26:0]];
  logic [255:0] phys_mem [logic [26:0]];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic finish_bench();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Default content of a never-written line: four distinct, index-dependent beats.
  function automatic logic [255:0] init_line(input logic [26:0] idx);
    logic [255:0] l;
    for (int b = 0; b < 4; b++)
      l[64*b +: 64] = {idx, 5'(b), 32'hC0DE_0000 ^ (32'(idx) * 32'd7 + 32'(b))};
    return l;
  endfunction

  function automatic logic [255:0] ref_line(input logic [26:0] idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_line(idx);
  endfunction

  function automatic logic [255:0] phys_line(input logic [26:0] idx);
    return phys_mem.exists(idx) ? phys_mem[idx] : init_line(idx);
  endfunction

  // Memory responder: decides mem_resp on the falling edge; writes commit to
  // the memory image only when the whole burst of four beats has been taken.
  int           rsp_beat = 0;
  int           rsp_v;
  int           wait_pct = 0;
  int           pat_q[$];
  logic [255:0] rsp_line;
  logic [255:0] wr_acc = '0;

  always @(negedge clk) begin
    if (rst) begin
      rsp_beat = 0;
      mem_resp = 1'b0;
    end else if (mem_read || mem_write) begin
      if (pat_q.size() > 0) rsp_v = pat_q.pop_front();
      else rsp_v = ($urandom_range(0, 99) >= wait_pct) ? 1 : 0;
      mem_resp = (rsp_v != 0);
      rsp_line = phys_line(mem_address[31:5]);
      mem_rdata = mem_read ? rsp_line[64*rsp_beat +: 64] : {$urandom, $urandom};
      if (mem_resp) begin
        if (mem_write) begin
          wr_acc[64*rsp_beat +: 64] = mem_wdata;
          if (rsp_beat == 3) phys_mem[mem_address[31:5]] = wr_acc;
        end
        rsp_beat = (rsp_beat + 1) % 4;
      end
    end else begin
      rsp_beat  = 0;
      mem_resp  = ($urandom_range(0, 1) == 1);
      mem_rdata = {$urandom, $urandom};
    end
  end

  // Monitor: checks every accepted beat against the head of the scoreboard
  // and retires the head on pmem_resp.
  int   nb = 0;
  bit   prev_resp = 1'b0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  exp_t me;

  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      nb = 0;
      prev_resp = 1'b0;
    end else begin
      if (mem_read && mem_write) fail("mem_rw_both");
      if (mem_read || mem_write) begin
        if (exp_q.size() == 0) fail("bus_unexpected");
        else if (mem_resp) begin
          me = exp_q[0];
          chk("burst_dir", mem_read, me.is_rd);
          chk("burst_addr", mem_address, me.addr);
          if (mem_write && nb < 4) chk("wr_beat", mem_wdata, me.line[64*nb +: 64]);
          nb++;
        end
      end
      if (pmem_resp) begin
        if (prev_resp) fail("resp_two_cycles");
        if (exp_q.size() == 0) fail("resp_unexpected");
        else begin
          me = exp_q.pop_front();
          chk("beat_count", nb, 4);
          chk("resp_bus_idle", {mem_read, mem_write}, 2'b00);
          if (me.is_rd) chk("rd_line", pmem_rdata, me.line);
          done_cnt++;
          done_cyc = cyc;
        end
        nb = 0;
      end
      prev_resp = pmem_resp;
    end
  end

  int issue_cyc = 0;

  task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [255:0] wd, input bit commit);
    exp_t e;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = a;
    pmem_wdata   = wd;
    e.addr = {a[31:5], 5'd0};
    if (wr) begin
      e.is_rd = 1'b0;
      e.line  = wd;
      if (commit) ref_mem[a[31:5]] = wd;
    end else begin
      e.is_rd = 1'b1;
      e.line  = ref_line(a[31:5]);
    end
    exp_q.push_back(e);
    issue_cyc = cyc;
  endtask

  // Drop the request after the accept edge and scramble the inputs that the
  // adapter must no longer be looking at.
  task automatic release_req();
    @(posedge clk);
    #1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = $urandom;
    pmem_wdata   = {8{$urandom}};
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (done_cnt < target) begin
      fail("done_timeout");
      finish_bench();
    end
  endtask

  task automatic xfer(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] wd);
    int tgt;
    tgt = done_cnt + 1;
    issue(rd, wr, a, wd, 1'b1);
    release_req();
    wait_done(tgt);
  endtask

  initial begin
    #200000;
    fail("global_timeout");
    finish_bench();
  end

  logic [255:0] d_line;
  logic [26:0]  ridx;
  int           kind;
  int           d1;
  int           tgt;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pmem_resp", pmem_resp, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_rdata", pmem_rdata, 256'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_no_req", {mem_read, mem_write}, 2'b00);

    // Fixed read with minimum latency.
    wait_pct = 0;
    d_line = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
    phys_mem[27'h0000_1220 >> 5] = d_line;
    ref_mem[27'h0000_1220 >> 5]  = d_line;
    xfer(1'b1, 1'b0, 32'h0000_1234, '0);
    chk("read_latency", done_cyc - issue_cyc, 5);

    // Fixed write to an unaligned address.
    d_line = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
              64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
    xfer(1'b0, 1'b1, 32'h8000_003F, d_line);
    chk("write_latency", done_cyc - issue_cyc, 5);

    // Wait-state pattern during a read.
    pat_q = '{1, 0, 0, 1, 0, 1, 1};
    xfer(1'b1, 1'b0, 32'h0000_1220, '0);
    chk("waitstate_latency", done_cyc - issue_cyc, 8);

    // Both requests together: write wins.
    xfer(1'b1, 1'b1, 32'h8000_0040, {8{32'h5A5A_A5A5}});
    xfer(1'b1, 1'b0, 32'h8000_0044, '0);

    // Reset after three write beats: transfer dropped, memory image untouched.
    issue(1'b0, 1'b1, 32'h8000_0020, {8{32'hDEAD_BEEF}}, 1'b0);
    release_req();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    void'(exp_q.pop_front());
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_mem_write", mem_write, 1'b0);
    chk("abort_mem_read", mem_read, 1'b0);
    chk("abort_pmem_resp", pmem_resp, 1'b0);
    chk("abort_rdata_clear", pmem_rdata, 256'd0);
    repeat (3) @(posedge clk);
    #1;
    xfer(1'b1, 1'b0, 32'h8000_0020, '0);
    chk("after_abort_latency", done_cyc - issue_cyc, 5);

    // Back-to-back reads with pmem_read held through DONE.
    tgt = done_cnt + 1;
    issue(1'b1, 1'b0, 32'h0000_1230, '0, 1'b1);
    exp_q.push_back(exp_q[exp_q.size()-1]);
    wait_done(tgt);
    d1 = done_cyc;
    @(posedge clk);
    #1;
    pmem_read = 1'b0;
    wait_done(tgt + 1);
    chk("b2b_latency", done_cyc - d1, 6);

    // Randomized traffic over a small set of lines.
    for (int t = 0; t < 60; t++) begin
      wait_pct = $urandom_range(0, 60);
      kind = $urandom_range(0, 2);
      ridx = 27'h0400_000 + 27'($urandom_range(0, 11));
      xfer(kind != 1, kind != 0, {ridx, 5'($urandom)}, {8{$urandom}});
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end

    for (int i = 0; i < 12; i++) begin
      ridx = 27'h0400_000 + 27'(i);
      chk("mem_image", phys_line(ridx), ref_line(ridx));
    end
    chk("scoreboard_empty", exp_q.size(), 0);
    finish_bench();
  end

endmodule
